// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: RAM op codes and FSM encoding.
package ram_fifo_ctrl_pkg;

  typedef logic [1:0] ram_op_t;

  localparam ram_op_t OP_IDLE = 2'b00;
  localparam ram_op_t OP_WR   = 2'b01;
  localparam ram_op_t OP_RD   = 2'b10;
  localparam ram_op_t OP_RW   = 2'b11;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t INIT   = 2'd0;
  localparam fsm_state_t IDLE   = 2'd1;
  localparam fsm_state_t ACTIVE = 2'd2;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of producer/consumer requests, RAM initiator signals and FIFO status.
interface ram_fifo_ctrl_if #(
  parameter int unsigned RAM_WIDTH = 4,
  parameter int unsigned ADDR_SIZE = 3
);

  logic                 push;
  logic [RAM_WIDTH-1:0] push_data;
  logic                 pop;
  logic                 enable;
  logic [1:0]           state;
  logic [RAM_WIDTH-1:0] data_in;
  logic [ADDR_SIZE-1:0] addr_in;
  logic [ADDR_SIZE-1:0] addr_out;
  logic [RAM_WIDTH-1:0] data_out_c;
  logic [RAM_WIDTH-1:0] pop_data;
  logic                 pop_valid;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_SIZE:0]   count;
  logic                 error;

  // Controller side.
  modport slave (
    input  push, push_data, pop, data_out_c,
    output enable, state, data_in, addr_in, addr_out, pop_data, pop_valid,
    output fifo_full, fifo_empty, almost_full, almost_empty, count, error
  );

  // Data path / RAM side.
  modport master (
    output push, push_data, pop, data_out_c,
    input  enable, state, data_in, addr_in, addr_out, pop_data, pop_valid,
    input  fifo_full, fifo_empty, almost_full, almost_empty, count, error
  );

endinterface

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// Wrap-around address pointer with increment enable; wraps from Depth-1 to 0.
module fifo_ptr #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] ptr_o
);

  logic [Width-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == Width'(Depth - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external single-cycle RAM as a circular buffer.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WIDTH    = 4,
  parameter int unsigned RAM_DEPTH    = 8,
  parameter int unsigned ADDR_SIZE    = 3,
  parameter int unsigned ALMOST_FULL  = 6,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic           clk,
  input  logic           reset_L,
  ram_fifo_ctrl_if.slave bus
);

  logic [ADDR_SIZE:0]   count_q, count_d;
  fsm_state_t           fsm_q, fsm_d;
  logic                 err_q, err_d;
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic [ADDR_SIZE-1:0] addr_in_q, addr_out_q;
  logic [RAM_WIDTH-1:0] data_in_q, pop_data_q, pop_data;
  logic                 pop_valid_q;
  logic                 running, push_acc, pop_acc;
  ram_op_t              op;

  // Requests seen during INIT are dropped silently; acceptance uses the registered count.
  always_comb begin
    running  = (fsm_q != INIT);
    push_acc = running && bus.push && (count_q < (ADDR_SIZE + 1)'(RAM_DEPTH));
    pop_acc  = running && bus.pop && (count_q != '0);
    err_d    = err_q | (running && ((bus.push && !push_acc) || (bus.pop && !pop_acc)));
    op       = {pop_acc, push_acc};
  end

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      INIT:    fsm_d = IDLE;
      IDLE:    if (push_acc) fsm_d = ACTIVE;
      ACTIVE:  if (count_d == '0) fsm_d = IDLE;
      default: fsm_d = INIT;
    endcase
  end

  fifo_ptr #(
    .Width (ADDR_SIZE),
    .Depth (RAM_DEPTH)
  ) u_wr_ptr (
    .clk_i  (clk),
    .rst_ni (reset_L),
    .inc_i  (push_acc),
    .ptr_o  (wr_ptr)
  );

  fifo_ptr #(
    .Width (ADDR_SIZE),
    .Depth (RAM_DEPTH)
  ) u_rd_ptr (
    .clk_i  (clk),
    .rst_ni (reset_L),
    .inc_i  (pop_acc),
    .ptr_o  (rd_ptr)
  );

  // RAM returns read data one cycle after the read op; capture it then, hold otherwise.
  assign pop_data = pop_valid_q ? bus.data_out_c : pop_data_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fsm_q       <= INIT;
      count_q     <= '0;
      err_q       <= 1'b0;
      addr_in_q   <= '0;
      addr_out_q  <= '0;
      data_in_q   <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      count_q     <= count_d;
      err_q       <= err_d;
      pop_valid_q <= pop_acc;
      pop_data_q  <= pop_data;
      if (push_acc) begin
        addr_in_q <= wr_ptr;
        data_in_q <= bus.push_data;
      end
      if (pop_acc) begin
        addr_out_q <= rd_ptr;
      end
    end
  end

  assign bus.state        = op;
  assign bus.enable       = (op != OP_IDLE);
  assign bus.addr_in      = push_acc ? wr_ptr : addr_in_q;
  assign bus.data_in      = push_acc ? bus.push_data : data_in_q;
  assign bus.addr_out     = pop_acc ? rd_ptr : addr_out_q;
  assign bus.pop_data     = pop_data;
  assign bus.pop_valid    = pop_valid_q;
  assign bus.count        = count_q;
  assign bus.error        = err_q;
  assign bus.fifo_full    = (count_q == (ADDR_SIZE + 1)'(RAM_DEPTH));
  assign bus.fifo_empty   = (count_q == '0);
  assign bus.almost_full  = (count_q >= (ADDR_SIZE + 1)'(ALMOST_FULL));
  assign bus.almost_empty = (count_q <= (ADDR_SIZE + 1)'(ALMOST_EMPTY));

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 8x4 RAM behind it.
module tb_ram_fifo_ctrl;

  logic clk;
  logic reset_L;

  ram_fifo_ctrl_if #(.RAM_WIDTH(4), .ADDR_SIZE(3)) bus ();

  ram_fifo_ctrl #(
    .RAM_WIDTH    (4),
    .RAM_DEPTH    (8),
    .ADDR_SIZE    (3),
    .ALMOST_FULL  (6),
    .ALMOST_EMPTY (2)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: write and registered read on the rising edge, contents never reset.
  logic [3:0] mem [8];
  always @(posedge clk) begin
    if (bus.enable && bus.state[0]) mem[bus.addr_in] <= bus.data_in;
    if (bus.enable && bus.state[1]) bus.data_out_c <= mem[bus.addr_out];
  end

  int checks   = 0;
  int failures = 0;

  logic [3:0] model [$];
  logic [3:0] exp_q [$];
  int         wp, rp;
  int         last_ai, last_ao, last_di;
  bit         err_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    model.delete();
    exp_q.delete();
    wp = 0; rp = 0; last_ai = 0; last_ao = 0; last_di = 0; err_m = 0;
  endtask

  task automatic check_reset();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_enable", int'(bus.enable), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_addr_in", int'(bus.addr_in), 0);
    chk("rst_addr_out", int'(bus.addr_out), 0);
    chk("rst_data_in", int'(bus.data_in), 0);
    chk("rst_pop_data", int'(bus.pop_data), 0);
    chk("rst_pop_valid", int'(bus.pop_valid), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_empty", int'(bus.fifo_empty), 1);
    chk("rst_aempty", int'(bus.almost_empty), 1);
    chk("rst_full", int'(bus.fifo_full), 0);
    chk("rst_afull", int'(bus.almost_full), 0);
  endtask

  // One clock of stimulus; rel releases reset on this cycle, which is then the INIT cycle.
  task automatic step(input bit p, input logic [3:0] d, input bit q, input bit rel);
    bit pa, qa;
    int sz, e_ai, e_ao, e_di;
    @(negedge clk);
    if (rel) reset_L = 1'b1;
    bus.push = p; bus.push_data = d; bus.pop = q;
    #1;
    sz = model.size();
    pa = p && !rel && (sz < 8);
    qa = q && !rel && (sz > 0);
    e_ai = pa ? wp : last_ai;
    e_di = pa ? int'(d) : last_di;
    e_ao = qa ? rp : last_ao;
    chk("state", int'(bus.state), int'({qa, pa}));
    chk("enable", int'(bus.enable), int'(pa || qa));
    chk("addr_in", int'(bus.addr_in), e_ai);
    chk("data_in", int'(bus.data_in), e_di);
    chk("addr_out", int'(bus.addr_out), e_ao);
    chk("count", int'(bus.count), sz);
    chk("full", int'(bus.fifo_full), int'(sz == 8));
    chk("empty", int'(bus.fifo_empty), int'(sz == 0));
    chk("afull", int'(bus.almost_full), int'(sz >= 6));
    chk("aempty", int'(bus.almost_empty), int'(sz <= 2));
    chk("error", int'(bus.error), int'(err_m));
    last_ai = e_ai; last_di = e_di; last_ao = e_ao;
    if (pa) wp = (wp + 1) % 8;
    if (qa) rp = (rp + 1) % 8;
    if (!rel) err_m = err_m | (p && !pa) | (q && !qa);
    if (qa) exp_q.push_back(model.pop_front());
    if (pa) model.push_back(d);
  endtask

  // A pop accepted in one cycle must show pop_valid with its word in the next.
  always @(negedge clk) begin
    if (reset_L) begin
      chk("pop_valid", int'(bus.pop_valid), int'(exp_q.size() > 0));
      if (bus.pop_valid && exp_q.size() > 0) begin
        chk("pop_data", int'(bus.pop_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset_L = 1'b0;
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #2 check_reset();

    // Push offered during INIT is dropped without error.
    step(1'b1, 4'hE, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b0, 1'b0);
    chk("full_count", int'(bus.count), 8);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("overflow_err", int'(bus.error), 1);

    for (int i = 0; i < 8; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("drained_empty", int'(bus.fifo_empty), 1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("underflow_en", int'(bus.enable), 0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("err_sticky", int'(bus.error), 1);

    // Bring pointers to wr=6 / rd=3 with three words resident.
    for (int i = 0; i < 6; i++) step(1'b1, 4'(10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'(5 + i), 1'b1, 1'b0);
    chk("rw_addr_in_wrap", int'(bus.addr_in), 1);
    chk("rw_count", int'(bus.count), 3);

    step(1'b1, 4'd2, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b1, 1'b0);

    // Reset lands while the last pop's data is in flight.
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    clear_model();
    #1 check_reset();
    bus.push = 1'b0; bus.pop = 1'b0;

    step(1'b1, 4'd3, 1'b1, 1'b1);
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("after_reset_err", int'(bus.error), 0);

    @(negedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

FIFO controller that acts as the initiator for the 8x4 RAM block. It turns producer push / consumer pop requests into RAM operation codes, write/read addresses and write data, tracks occupancy, and presents the RAM read data with a valid strobe. It sits between the data path and the RAM, so the RAM becomes a circular FIFO.

## Interface
Parameters:
- RAM_WIDTH, 4, data bits per word
- RAM_DEPTH, 8, number of entries
- ADDR_SIZE, 3, address bits (log2 RAM_DEPTH)
- ALMOST_FULL, 6, occupancy at or above which almost_full is set
- ALMOST_EMPTY, 2, occupancy at or below which almost_empty is set

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_L  in  1  asynchronous, active-low reset
- push  in  1  producer write request
- push_data  in  RAM_WIDTH  word to write
- pop  in  1  consumer read request
- enable  out  1  RAM enable
- state  out  2  RAM op code: 00 idle, 01 write, 10 read, 11 read+write
- data_in  out  RAM_WIDTH  RAM write data
- addr_in  out  ADDR_SIZE  RAM write address
- addr_out  out  ADDR_SIZE  RAM read address
- data_out_c  in  RAM_WIDTH  RAM read data, registered, valid one cycle after a read op
- pop_data  out  RAM_WIDTH  popped word
- pop_valid  out  1  pop_data valid this cycle
- fifo_full, fifo_empty, almost_full, almost_empty  out  1 each  status flags
- count  out  ADDR_SIZE+1  occupancy, 0..RAM_DEPTH
- error  out  1  sticky overflow/underflow flag

## Operation
- Acceptance is evaluated on registered count at the start of the cycle: push accepted iff push && count<RAM_DEPTH; pop accepted iff pop && count>0.
- Rejected push (full) or pop (empty) sets error; the request is dropped and pointers, count and RAM op are unaffected by it.
- Accepted push: state bit0=1, addr_in=wr_ptr, data_in=push_data; wr_ptr increments.
- Accepted pop: state bit1=1, addr_out=rd_ptr; rd_ptr increments.
- Both accepted: state=11; count unchanged. Read and write never target the same address (full and empty are excluded by the acceptance rule).
- enable=1 iff state!=00. When idle, addr/data outputs hold their last values.
- Pointers wrap from RAM_DEPTH-1 to 0. count = previous + push_acc - pop_acc.
- Flags are decoded from registered count: fifo_full (count==RAM_DEPTH), fifo_empty (count==0), almost_full (count>=ALMOST_FULL), almost_empty (count<=ALMOST_EMPTY).
- FSM states:
  - INIT: one cycle after reset release; RAM op forced to 00; goes to IDLE.
  - IDLE: count==0.
  - ACTIVE: count>0.
  - IDLE->ACTIVE on an accepted push. ACTIVE->IDLE when the next count is 0.
  - Requests arriving in INIT are rejected without setting error.
- error clears only on reset.

## Timing
- While reset_L=0, asynchronously: pointers=0, count=0, state=00, enable=0, data_in/addr_in/addr_out=0, pop_data=0, pop_valid=0, error=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, FSM=INIT.
- RAM op outputs are combinational from the requests and registered state, in the same cycle as the request.
- pop_valid is asserted exactly one cycle after an accepted pop; pop_data=data_out_c in that cycle, else pop_data holds its value.
- Flags and count update on the edge ending the accepting cycle.
- A reset mid-stream drops any in-flight pop_valid and clears all state. RAM contents are not cleared and are ignored afterwards.

## Structure
- Shared package holds:
  - RAM op-code constants (OP_IDLE, OP_WR, OP_RD, OP_RW)
  - FSM state encoding (INIT, IDLE, ACTIVE)
- Sub-module fifo_ptr: ADDR_SIZE-bit wrap-around counter with increment enable and async reset, instantiated twice (write and read pointers).

## Test plan
- Reset, then 8 pushes of 1..8 with no pops:
  - state=01, addr_in goes 0..7
  - count reaches 8; fifo_full=1; almost_full is first set after the 6th push
  - error=0
- Push 9 while full -> state=00, count stays 8, error=1 and remains 1.
- 8 pops after the fill:
  - addr_out goes 0..7
  - pop_valid is set one cycle after each pop, pop_data=1..8 in order
  - fifo_empty=1 at the end
- Pop while empty -> enable=0, pop_valid stays 0, error=1.
- Count=3 with pointers at 6/3, then 4 cycles of simultaneous push+pop:
  - state=11, count stays 3
  - addr_in wraps 6,7,0,1
- Reset_L dropped mid-burst at count=5 -> all outputs at their reset values in the same cycle. The first pop after INIT returns the first word pushed after reset.
